// File: rtl/draw_sequencer.sv
// Frame sequencer: runs a fill pass, then an optional shape pass, per draw request.
// Holds one request in reserve and muxes the active engine's pixel stream to the VGA adapter.
module draw_sequencer #(
  parameter logic [2:0] FILL_COLOUR  = 3'b000,
  parameter logic [2:0] SHAPE_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       rst_n,
  // draw request
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_centre_x,
  input  logic [6:0] req_centre_y,
  input  logic [7:0] req_diameter,
  // fill engine
  output logic       fill_start,
  input  logic       fill_done,
  output logic [2:0] fill_colour,
  input  logic [7:0] fill_vga_x,
  input  logic [6:0] fill_vga_y,
  input  logic [2:0] fill_vga_colour,
  input  logic       fill_vga_plot,
  // shape engine
  output logic       shape_start,
  input  logic       shape_done,
  output logic [2:0] shape_colour,
  output logic [7:0] centre_x,
  output logic [6:0] centre_y,
  output logic [7:0] diameter,
  input  logic [7:0] shape_vga_x,
  input  logic [6:0] shape_vga_y,
  input  logic [2:0] shape_vga_colour,
  input  logic       shape_vga_plot,
  // muxed pixel stream
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  // status
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StFill, StGap, StShape, StFin} state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] d;
  } geom_t;

  state_e state_q, state_d;
  geom_t  pend_q, pend_d;
  geom_t  geom_q, geom_d;
  logic   pend_full_q, pend_full_d;
  logic   done_q, done_d;

  geom_t  req_geom;
  logic   accept;
  logic   load;

  assign req_geom  = '{x: req_centre_x, y: req_centre_y, d: req_diameter};
  assign req_ready = ~pend_full_q;
  assign accept    = req_valid & req_ready;
  // A waiting entry always wins over a new request when a frame is launched.
  assign load      = (state_q == StIdle) & (pend_full_q | accept);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load) state_d = StFill;
      StFill:  if (fill_done) state_d = StGap;
      StGap:   state_d = (geom_q.d != 8'd0) ? StShape : StFin;
      StShape: if (shape_done) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    fill_start  = 1'b0;
    shape_start = 1'b0;
    busy        = (state_q != StIdle);
    vga_x       = 8'd0;
    vga_y       = 7'd0;
    vga_colour  = 3'd0;
    vga_plot    = 1'b0;
    unique case (state_q)
      StFill: begin
        fill_start = 1'b1;
        vga_x      = fill_vga_x;
        vga_y      = fill_vga_y;
        vga_colour = fill_vga_colour;
        vga_plot   = fill_vga_plot;
      end
      StGap: begin
        // Coordinates still follow the fill engine, but nothing is plotted.
        vga_x      = fill_vga_x;
        vga_y      = fill_vga_y;
        vga_colour = fill_vga_colour;
      end
      StShape: begin
        shape_start = 1'b1;
        vga_x       = shape_vga_x;
        vga_y       = shape_vga_y;
        vga_colour  = shape_vga_colour;
        vga_plot    = shape_vga_plot;
      end
      default: ;
    endcase
  end

  // Pending buffer, frame geometry and done flag
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    geom_d      = geom_q;
    done_d      = done_q;

    if (load) begin
      geom_d = pend_full_q ? pend_q : req_geom;
      done_d = 1'b0;
    end

    if ((state_q == StIdle) && pend_full_q) begin
      pend_full_d = 1'b0;
    end

    // An accept in an idle sequencer with nothing waiting goes straight to the geometry.
    if (accept && !((state_q == StIdle) && !pend_full_q)) begin
      pend_d      = req_geom;
      pend_full_d = 1'b1;
    end

    if (state_d == StFin) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      geom_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      geom_q      <= geom_d;
      done_q      <= done_d;
    end
  end

  assign centre_x     = geom_q.x;
  assign centre_y     = geom_q.y;
  assign diameter     = geom_q.d;
  assign done         = done_q;
  assign fill_colour  = FILL_COLOUR;
  assign shape_colour = SHAPE_COLOUR;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: directed frames plus randomized traffic, compared every cycle
// against a frame-level reference model.
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [7:0] req_centre_x, req_diameter;
  logic [6:0] req_centre_y;
  logic       fill_start, fill_done, shape_start, shape_done;
  logic [2:0] fill_colour, shape_colour;
  logic [7:0] centre_x, diameter;
  logic [6:0] centre_y;
  logic [7:0] fill_vga_x, shape_vga_x, vga_x;
  logic [6:0] fill_vga_y, shape_vga_y, vga_y;
  logic [2:0] fill_vga_colour, shape_vga_colour, vga_colour;
  logic       fill_vga_plot, shape_vga_plot, vga_plot;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  draw_sequencer #(.FILL_COLOUR(3'b000), .SHAPE_COLOUR(3'b010)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_centre_x     (req_centre_x),
    .req_centre_y     (req_centre_y),
    .req_diameter     (req_diameter),
    .fill_start       (fill_start),
    .fill_done        (fill_done),
    .fill_colour      (fill_colour),
    .fill_vga_x       (fill_vga_x),
    .fill_vga_y       (fill_vga_y),
    .fill_vga_colour  (fill_vga_colour),
    .fill_vga_plot    (fill_vga_plot),
    .shape_start      (shape_start),
    .shape_done       (shape_done),
    .shape_colour     (shape_colour),
    .centre_x         (centre_x),
    .centre_y         (centre_y),
    .diameter         (diameter),
    .shape_vga_x      (shape_vga_x),
    .shape_vga_y      (shape_vga_y),
    .shape_vga_colour (shape_vga_colour),
    .shape_vga_plot   (shape_vga_plot),
    .vga_x            (vga_x),
    .vga_y            (vga_y),
    .vga_colour       (vga_colour),
    .vga_plot         (vga_plot),
    .busy             (busy),
    .done             (done)
  );

  // ---------------- reference model ----------------
  localparam int PhIdle = 0, PhFill = 1, PhGap = 2, PhShape = 3, PhFin = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] d;
  } geo_t;

  int   m_ph;
  geo_t m_cur;
  geo_t m_pend[$];
  logic m_done;

  task automatic model_reset();
    m_ph   = PhIdle;
    m_cur  = '0;
    m_done = 1'b0;
    m_pend.delete();
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_step();
    bit   acc;
    geo_t r;
    acc = req_valid && (m_pend.size() == 0);
    r   = {req_centre_x, req_centre_y, req_diameter};
    case (m_ph)
      PhIdle: begin
        if (m_pend.size() != 0) begin
          m_cur  = m_pend.pop_front();
          m_done = 1'b0;
          m_ph   = PhFill;
        end else if (acc) begin
          m_cur  = r;
          m_done = 1'b0;
          m_ph   = PhFill;
          acc    = 0;
        end
      end
      PhFill:  if (fill_done) m_ph = PhGap;
      PhGap:   m_ph = (m_cur.d != 0) ? PhShape : PhFin;
      PhShape: if (shape_done) m_ph = PhFin;
      default: m_ph = PhIdle;
    endcase
    if (m_ph == PhFin) m_done = 1'b1;
    if (acc) m_pend.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    logic       ep;
    #1;
    ex = 0; ey = 0; ec = 0; ep = 0;
    if (m_ph == PhFill || m_ph == PhGap) begin
      ex = fill_vga_x; ey = fill_vga_y; ec = fill_vga_colour;
      ep = fill_vga_plot && (m_ph == PhFill);
    end else if (m_ph == PhShape) begin
      ex = shape_vga_x; ey = shape_vga_y; ec = shape_vga_colour; ep = shape_vga_plot;
    end
    chk("req_ready", req_ready, m_pend.size() == 0);
    chk("busy", busy, m_ph != PhIdle);
    chk("fill_start", fill_start, m_ph == PhFill);
    chk("shape_start", shape_start, m_ph == PhShape);
    chk("done", done, m_done);
    chk("geometry", {centre_x, centre_y, diameter}, m_cur);
    chk("colours", {fill_colour, shape_colour}, 6'b000_010);
    chk("vga", {vga_x, vga_y, vga_colour, vga_plot}, {ex, ey, ec, ep});
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [7:0] x, input logic [6:0] y, input logic [7:0] d);
    req_valid = 1'b1; req_centre_x = x; req_centre_y = y; req_diameter = d;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    model_reset();
    check_all();
    chk("rst_now_idle", {fill_start, shape_start, busy, done, req_ready}, 5'b00001);
    chk("rst_now_geom", {centre_x, centre_y, diameter}, 0);
    tick();
    rst_n = 1'b1;
  endtask

  int fs_cnt, ss_cnt;

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_centre_x = 0; req_centre_y = 0; req_diameter = 0;
    fill_done = 0; shape_done = 0;
    fill_vga_x = 0; fill_vga_y = 0; fill_vga_colour = 0; fill_vga_plot = 0;
    shape_vga_x = 0; shape_vga_y = 0; shape_vga_colour = 0; shape_vga_plot = 0;
    model_reset();
    #3;
    check_all();
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Stray done pulses in IDLE do nothing.
    fill_done = 1; shape_done = 1; check_all(); tick();
    fill_done = 0; shape_done = 0; check_all();
    chk("idle_ignores_done", busy, 0);
    tick();

    // Full frame (80,60,80) with a long fill.
    set_req(8'd80, 7'd60, 8'd80); check_all(); tick();
    req_valid = 0;
    fs_cnt = 0;
    for (int i = 0; i < 19200; i++) begin
      fill_done = (i == 19199);
      check_all();
      if (fill_start) fs_cnt++;
      tick();
    end
    chk("fill_start_cycles", fs_cnt, 19200);
    fill_done = 0; check_all();
    chk("gap_no_starts", {fill_start, shape_start}, 2'b00);
    tick();
    ss_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      shape_done = (i == 499);
      check_all();
      if (shape_start) ss_cnt++;
      tick();
    end
    chk("shape_start_cycles", ss_cnt, 500);
    shape_done = 0; check_all();
    chk("fin_done", done, 1);
    chk("fin_centre_x", centre_x, 8'd80);
    tick();
    check_all();
    chk("idle_done_held", {busy, done}, 2'b01);
    tick();

    // Zero diameter skips the shape pass.
    set_req(8'd7, 7'd3, 8'd0); check_all(); tick();
    req_valid = 0; fill_done = 1; check_all(); tick();
    fill_done = 0; check_all(); tick();
    check_all();
    chk("d0_fin_done", done, 1);
    chk("d0_no_shape", shape_start, 0);
    tick();

    // Queued request during FILL, blocked third request.
    set_req(8'd10, 7'd5, 8'd3); check_all(); tick();
    set_req(8'd40, 7'd30, 8'd20); check_all(); tick();
    set_req(8'd50, 7'd40, 8'd60); check_all();
    chk("ready_low_when_full", req_ready, 0);
    tick();
    fill_done = 1; check_all(); tick();
    fill_done = 0; check_all(); tick();
    shape_done = 1; check_all(); tick();
    shape_done = 0; check_all(); tick();
    check_all();
    chk("one_idle_cycle", busy, 0);
    tick();
    check_all();
    chk("queued_geometry", {centre_x, centre_y, diameter}, {8'd40, 7'd30, 8'd20});
    chk("ready_after_drain", req_ready, 1);
    tick();
    check_all();
    chk("third_accepted", req_ready, 0);
    req_valid = 0;

    // Mux gating: shape plot during FILL and fill plot during GAP never reach vga_plot.
    fill_vga_x = 8'h12; fill_vga_plot = 0; shape_vga_x = 8'h34; shape_vga_plot = 1;
    check_all();
    chk("fill_sel_x", vga_x, 8'h12);
    chk("fill_blocks_shape_plot", vga_plot, 0);
    fill_done = 1; tick();
    fill_done = 0; fill_vga_plot = 1; check_all();
    chk("gap_plot_low", vga_plot, 0);
    chk("gap_sel_x", vga_x, 8'h12);
    tick();
    check_all();
    chk("shape_sel_x", vga_x, 8'h34);
    chk("shape_plot", vga_plot, 1);
    chk("pending_before_reset", req_ready, 0);

    // Reset in SHAPE with a full pending slot: nothing resumes.
    async_reset();
    for (int i = 0; i < 4; i++) begin
      fill_done = 1; shape_done = 1; check_all(); tick();
    end
    chk("no_resume", busy, 0);

    // Randomized traffic.
    for (int n = 0; n < 6000; n++) begin
      req_valid       = ($urandom_range(0, 2) == 0);
      req_centre_x    = 8'($urandom);
      req_centre_y    = 7'($urandom);
      req_diameter    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      fill_done       = ($urandom_range(0, 7) == 0);
      shape_done      = ($urandom_range(0, 5) == 0);
      fill_vga_x      = 8'($urandom);
      fill_vga_y      = 7'($urandom);
      fill_vga_colour = 3'($urandom);
      fill_vga_plot   = 1'($urandom);
      shape_vga_x     = 8'($urandom);
      shape_vga_y     = 7'($urandom);
      shape_vga_colour = 3'($urandom);
      shape_vga_plot  = 1'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        check_all();
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
